if_stage: RTL and testbench

Instruction-fetch stage, directly upstream of id_stage. It owns the PC and issues one request at a time to instruction memory over a req/gnt/rvalid handshake. It delivers a registered instruction, its PC and a bubble flag: `instruction` feeds the id_stage instruction input, `pc_out` feeds pc_in, and `halt_fetch` feeds halt_fetch. It also handles stalls from the control unit, redirects from ex_stage and a permanent halt.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/if_stage.sv | 150 +++++++++++++++
 tb/tb_if_stage.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: state encoding, reset/bubble
// defaults and the PC step.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN,
    ST_HALTED
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory request
// at a time over req/gnt/rvalid, and presents a registered instruction, its PC
// and a bubble flag to the decode stage. Handles stall, redirect and halt.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        halt_fetch
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  fetch_pc;
  logic [31:0]  buf_instr;
  logic [31:0]  buf_pc;
  logic         halt_pend;
  logic         grant;

  // Request only from REQ and only when nothing upstream wants the stage quiet.
  always_comb begin
    imem_req  = (state == ST_REQ) && !stall && !redirect && !halt_req;
    imem_addr = pc;
    grant     = imem_req && imem_gnt;
  end

  // Fetch FSM and output registers; priority reset > halt > redirect > stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      fetch_pc    <= '0;
      buf_instr   <= '0;
      buf_pc      <= '0;
      halt_pend   <= 1'b0;
      instruction <= NOP_WORD;
      pc_out      <= '0;
      halt_fetch  <= 1'b1;
    end else if (state == ST_HALTED) begin
      instruction <= NOP_WORD;
      halt_fetch  <= 1'b1;
    end else if (halt_req) begin
      instruction <= NOP_WORD;
      halt_fetch  <= 1'b1;
      // A request still in flight must be drained before parking.
      if ((state == ST_WAIT || state == ST_DRAIN) && !imem_rvalid) begin
        state     <= ST_DRAIN;
        halt_pend <= 1'b1;
      end else begin
        state <= ST_HALTED;
      end
    end else if (redirect) begin
      pc          <= word_align(redirect_pc);
      instruction <= NOP_WORD;
      halt_fetch  <= 1'b1;
      case (state)
        ST_WAIT:  state <= imem_rvalid ? ST_REQ : ST_DRAIN;
        ST_DRAIN: begin
          if (imem_rvalid) begin
            state <= halt_pend ? ST_HALTED : ST_REQ;
          end
        end
        default:  state <= ST_REQ;
      endcase
    end else begin
      // Any unstalled cycle without a delivery emits a bubble; a delivery
      // below overrides these defaults.
      if (!stall) begin
        instruction <= NOP_WORD;
        halt_fetch  <= 1'b1;
      end
      case (state)
        ST_IDLE: state <= ST_REQ;
        ST_REQ: begin
          if (grant) begin
            fetch_pc <= pc;
            pc       <= pc + PC_STEP;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (!stall) begin
              instruction <= imem_rdata;
              pc_out      <= fetch_pc;
              halt_fetch  <= 1'b0;
              state       <= ST_REQ;
            end else begin
              buf_instr <= imem_rdata;
              buf_pc    <= fetch_pc;
              state     <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            instruction <= buf_instr;
            pc_out      <= buf_pc;
            halt_fetch  <= 1'b0;
            state       <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (imem_rvalid) begin
            state <= halt_pend ? ST_HALTED : ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bus-level tracker of the single outstanding grant, used by the checks below.
  logic gnt_outstanding;

  // Set on an accepted request, cleared when its response returns.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt_outstanding <= 1'b0;
    end else if (grant) begin
      gnt_outstanding <= 1'b1;
    end else if (imem_rvalid) begin
      gnt_outstanding <= 1'b0;
    end
  end

  a_single_outstanding: assert property (@(posedge clk) disable iff (!reset)
    grant |-> !gnt_outstanding);

  a_addr_aligned: assert property (@(posedge clk) disable iff (!reset)
    imem_addr[1:0] == 2'b00);

  a_no_req_when_busy: assert property (@(posedge clk) disable iff (!reset)
    (state inside {ST_WAIT, ST_HOLD, ST_DRAIN, ST_HALTED}) |-> !imem_req);

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: a memory responder with random grant/latency, a
// behavioural fetch model feeding an expected-output queue, and a monitor
// that compares the registered outputs every cycle.
module tb_if_stage;
  import mips_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        halt_fetch;

  if_stage #(.RESET_PC(RPC), .NOP_WORD(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_req),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .pc_out      (pc_out),
    .halt_fetch  (halt_fetch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        hf;
  } out_t;

  out_t        exp_q[$];
  out_t        mon_e;
  logic [31:0] gnt_log[$];

  // Memory responder configuration and state
  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  // Reference model state
  logic        known = 1'b0;
  logic [31:0] pc_m = RPC;
  logic        halted = 1'b0;
  logic        dut_wait = 1'b0;
  logic        in_idle = 1'b1;
  logic        item_live = 1'b0;
  logic [31:0] item_addr = '0;
  logic        buf_v = 1'b0;
  logic [31:0] buf_addr = '0;
  out_t        cur = '{instr: NOP, pc: 32'h0, hf: 1'b1};

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // One clock cycle: drive inputs, answer the bus, then advance the model.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic hr, input logic rs);
    logic        rv_now;
    logic        req_now;
    logic        gnt_now;
    logic        exp_req;
    logic        rv_live;
    logic [31:0] addr_now;
    logic [31:0] rv_addr;
    @(negedge clk);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    halt_req    = hr;
    reset       = rs;
    rv_now      = mem_busy && (mem_cnt == 0);
    imem_rvalid = rv_now;
    imem_rdata  = rv_now ? memfn(mem_addr) : $urandom;
    imem_gnt    = 1'b0;
    #1;
    req_now  = imem_req;
    addr_now = imem_addr;
    if (known) begin
      exp_req = !in_idle && !halted && !dut_wait && !buf_v && !st && !rd && !hr;
      chk("imem_req", {31'b0, req_now}, {31'b0, exp_req});
      if (req_now) chk("imem_addr", addr_now, pc_m);
    end
    imem_gnt = rs && !mem_busy && ($urandom_range(99) < gnt_pct);
    gnt_now  = req_now && imem_gnt;
    @(posedge clk);

    // memory side
    if (rv_now) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (gnt_now) begin
      mem_busy = 1'b1;
      mem_cnt  = $urandom_range(lat_max - 1, lat_min - 1);
      mem_addr = addr_now;
      gnt_log.push_back(addr_now);
    end

    // expected behaviour
    if (!rs) begin
      known     = 1'b1;
      halted    = 1'b0;
      pc_m      = RPC;
      item_live = 1'b0;
      dut_wait  = 1'b0;
      buf_v     = 1'b0;
      in_idle   = 1'b1;
      cur       = '{instr: NOP, pc: 32'h0, hf: 1'b1};
    end else begin
      in_idle = 1'b0;
      rv_live = rv_now && item_live;
      rv_addr = item_addr;
      if (rv_now) begin
        item_live = 1'b0;
        dut_wait  = 1'b0;
      end
      if (halted) begin
        cur.instr = NOP; cur.hf = 1'b1;
      end else if (hr) begin
        halted    = 1'b1;
        item_live = 1'b0;
        buf_v     = 1'b0;
        cur.instr = NOP; cur.hf = 1'b1;
      end else if (rd) begin
        pc_m      = rpc & ~32'h3;
        item_live = 1'b0;
        buf_v     = 1'b0;
        cur.instr = NOP; cur.hf = 1'b1;
      end else begin
        if (gnt_now) begin
          item_live = 1'b1;
          item_addr = pc_m;
          dut_wait  = 1'b1;
          pc_m      = pc_m + 32'd4;
        end
        if (st) begin
          if (rv_live) begin
            buf_v    = 1'b1;
            buf_addr = rv_addr;
          end
        end else if (buf_v) begin
          buf_v = 1'b0;
          cur   = '{instr: memfn(buf_addr), pc: buf_addr, hf: 1'b0};
        end else if (rv_live) begin
          cur = '{instr: memfn(rv_addr), pc: rv_addr, hf: 1'b0};
        end else begin
          cur.instr = NOP; cur.hf = 1'b1;
        end
      end
    end
    exp_q.push_back(cur);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  // Run idle cycles until a new grant is seen or the budget runs out.
  task automatic wait_grant(output logic [31:0] a, input int budget);
    int n0;
    n0 = gnt_log.size();
    a  = 32'hDEAD_BEEF;
    for (int i = 0; i < budget; i++) begin
      if (gnt_log.size() > n0) break;
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    end
    if (gnt_log.size() > n0) begin
      a = gnt_log[n0];
    end else begin
      checks++;
      failures++;
      $display("FAIL grant_timeout: no grant within %0d cycles at %0t", budget, $time);
    end
  endtask

  // Monitor: compare registered outputs against the expected stream.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("instruction", instruction, mon_e.instr);
        chk("pc_out", pc_out, mon_e.pc);
        chk("halt_fetch", {31'b0, halt_fetch}, {31'b0, mon_e.hf});
      end
    end
  end

  logic [31:0] ga;

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    halt_req = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // reset, then straight-line fetch of 0, 4, 8
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wait_grant(ga, 20);
      chk("seq_addr", ga, 32'(i * 4));
    end

    // stall through the rvalid cycle of 0x8 for three cycles
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

    // redirect while waiting on 0xC (no response yet, so it drains)
    lat_min = 2; lat_max = 2;
    wait_grant(ga, 20);
    chk("addr_0c", ga, 32'h0000_000C);
    cycle(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b1);
    wait_grant(ga, 20);
    chk("redirect_100", ga, 32'h0000_0100);

    // unaligned redirect target and PC wrap
    lat_min = 1; lat_max = 1;
    cycle(1'b0, 1'b1, 32'h0000_0203, 1'b0, 1'b1);
    wait_grant(ga, 20);
    chk("redirect_203", ga, 32'h0000_0200);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    wait_grant(ga, 20);
    chk("wrap_last", ga, 32'hFFFF_FFFC);
    wait_grant(ga, 20);
    chk("wrap_zero", ga, 32'h0000_0000);

    // halt while a request is outstanding, stay parked, then reset
    lat_min = 2; lat_max = 2;
    wait_grant(ga, 20);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    idle(20);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    wait_grant(ga, 20);
    chk("restart_after_halt", ga, RPC);

    // reset while holding a buffered instruction
    lat_min = 1; lat_max = 1;
    wait_grant(ga, 20);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    wait_grant(ga, 20);
    chk("restart_after_hold", ga, RPC);

    // randomized traffic
    gnt_pct = 70; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15))) : $urandom;
      cycle($urandom_range(99) < 25, $urandom_range(99) < 5, tgt,
            $urandom_range(199) < 1, !($urandom_range(99) < 1));
    end

    idle(4);
    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
